// File: rtl/memory_arbiter_if.sv
// Bundles the I-port, D-port and memory-side signals of the arbiter.
// master: the arbiter itself; slave: the caches plus the memory around it.
// All signals are plain 32-bit words or single-bit strobes.
interface memory_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_burst;
    logic        i_ack;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_done;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic        d_byte;
    logic        d_burst;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_done;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_master_enable;
    logic        mem_write_enable;
    logic        mem_byte_enable;

    modport master (
        input  i_req, i_addr, i_burst,
        input  d_req, d_addr, d_wdata, d_we, d_byte, d_burst,
        input  mem_data_out,
        output i_ack, i_rvalid, i_rdata, i_done,
        output d_ack, d_rvalid, d_rdata, d_done,
        output mem_addr, mem_data_in, mem_master_enable, mem_write_enable, mem_byte_enable
    );

    modport slave (
        output i_req, i_addr, i_burst,
        output d_req, d_addr, d_wdata, d_we, d_byte, d_burst,
        output mem_data_out,
        input  i_ack, i_rvalid, i_rdata, i_done,
        input  d_ack, d_rvalid, d_rdata, d_done,
        input  mem_addr, mem_data_in, mem_master_enable, mem_write_enable, mem_byte_enable
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory between the I and D ports; single, byte and wrapped line bursts.
// Latency: ack one cycle after req is sampled, each beat MEM_LATENCY cycles, rvalid/done the cycle after the last wait.
// Backpressure: losing requester holds req until ack; one transaction in flight, IDLE cycle between transactions.
module memory_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int LINE_WORDS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    memory_arbiter_if.master bus
);
    localparam int LB = $clog2(LINE_WORDS);
    localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_LATENCY - 1);
    localparam logic [LB-1:0] LAST_BEAT = LB'(LINE_WORDS - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q;
    logic          owner_q;        // 0 = I port, 1 = D port
    logic          last_grant_q;   // port granted most recently
    logic [31:2]   line_q;         // word address of the first beat
    logic          we_q;
    logic          burst_q;
    logic [LB-1:0] beat_q;
    logic [WW-1:0] wait_q;

    logic          i_ack_q, i_rvalid_q, i_done_q;
    logic          d_ack_q, d_rvalid_q, d_done_q;
    logic [31:0]   i_rdata_q, d_rdata_q;
    logic [31:0]   mem_addr_q, mem_data_in_q;
    logic          mem_master_enable_q, mem_write_enable_q, mem_byte_enable_q;

    logic          grant_d;
    logic [31:0]   addr_d;
    logic          we_d, byte_d, burst_d;
    logic [LB-1:0] idx_d;
    logic [31:0]   next_addr_d;
    logic          last_beat_d;

    // Arbitration choice and the wrapped address of the following burst beat.
    always_comb begin
        grant_d = bus.d_req;
        if (bus.i_req && bus.d_req) begin
            grant_d = ~last_grant_q;
        end
        addr_d      = grant_d ? bus.d_addr : bus.i_addr;
        we_d        = grant_d & bus.d_we;
        byte_d      = grant_d & bus.d_byte;
        burst_d     = grant_d ? (bus.d_burst & ~bus.d_we & ~bus.d_byte) : bus.i_burst;
        idx_d       = line_q[LB+1:2] + beat_q + LB'(1);
        next_addr_d = {line_q[31:LB+2], idx_d, 2'b00};
        last_beat_d = ~burst_q | (beat_q == LAST_BEAT);
    end

    // IDLE/ACCESS sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= IDLE;
            owner_q             <= 1'b0;
            last_grant_q        <= 1'b1;
            line_q              <= '0;
            we_q                <= 1'b0;
            burst_q             <= 1'b0;
            beat_q              <= '0;
            wait_q              <= '0;
            i_ack_q             <= 1'b0;
            i_rvalid_q          <= 1'b0;
            i_done_q            <= 1'b0;
            d_ack_q             <= 1'b0;
            d_rvalid_q          <= 1'b0;
            d_done_q            <= 1'b0;
            i_rdata_q           <= '0;
            d_rdata_q           <= '0;
            mem_addr_q          <= '0;
            mem_data_in_q       <= '0;
            mem_master_enable_q <= 1'b0;
            mem_write_enable_q  <= 1'b0;
            mem_byte_enable_q   <= 1'b0;
        end else begin
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state_q             <= ACCESS;
                        owner_q             <= grant_d;
                        last_grant_q        <= grant_d;
                        line_q              <= addr_d[31:2];
                        we_q                <= we_d;
                        burst_q             <= burst_d;
                        beat_q              <= '0;
                        wait_q              <= '0;
                        i_ack_q             <= ~grant_d;
                        d_ack_q             <= grant_d;
                        mem_addr_q          <= addr_d;
                        mem_data_in_q       <= grant_d ? bus.d_wdata : 32'h0;
                        mem_master_enable_q <= 1'b1;
                        mem_write_enable_q  <= we_d;
                        mem_byte_enable_q   <= byte_d;
                    end
                end
                ACCESS: begin
                    if (wait_q == LAST_WAIT) begin
                        wait_q <= '0;
                        if (!we_q) begin
                            if (owner_q) begin
                                d_rvalid_q <= 1'b1;
                                d_rdata_q  <= bus.mem_data_out;
                            end else begin
                                i_rvalid_q <= 1'b1;
                                i_rdata_q  <= bus.mem_data_out;
                            end
                        end
                        if (last_beat_d) begin
                            // Last beat: report completion and release the memory.
                            i_done_q            <= ~owner_q;
                            d_done_q            <= owner_q;
                            state_q             <= IDLE;
                            mem_addr_q          <= '0;
                            mem_data_in_q       <= '0;
                            mem_master_enable_q <= 1'b0;
                            mem_write_enable_q  <= 1'b0;
                            mem_byte_enable_q   <= 1'b0;
                        end else begin
                            beat_q     <= beat_q + LB'(1);
                            mem_addr_q <= next_addr_d;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.i_ack             = i_ack_q;
    assign bus.i_rvalid          = i_rvalid_q;
    assign bus.i_rdata           = i_rdata_q;
    assign bus.i_done            = i_done_q;
    assign bus.d_ack             = d_ack_q;
    assign bus.d_rvalid          = d_rvalid_q;
    assign bus.d_rdata           = d_rdata_q;
    assign bus.d_done            = d_done_q;
    assign bus.mem_addr          = mem_addr_q;
    assign bus.mem_data_in       = mem_data_in_q;
    assign bus.mem_master_enable = mem_master_enable_q;
    assign bus.mem_write_enable  = mem_write_enable_q;
    assign bus.mem_byte_enable   = mem_byte_enable_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: byte-addressed memory models, table of transactions, scoreboard queues.
// Two instances: MEM_LATENCY=1 (main) and MEM_LATENCY=3 (burst timing).
// Outputs sampled on the falling edge; requests driven on the falling edge.
module tb_memory_arbiter;
    logic clk;
    logic reset;
    logic mem_rst_n;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    memory_arbiter_if bus1();
    memory_arbiter_if bus3();

    memory_arbiter #(.MEM_LATENCY(1), .LINE_WORDS(4)) dut  (.clk(clk), .reset(reset), .bus(bus1));
    memory_arbiter #(.MEM_LATENCY(3), .LINE_WORDS(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(int a);
        return 8'(a * 37 + 11);
    endfunction

    // ---------------- memory models ----------------
    logic [7:0] mem1 [0:255];
    logic [7:0] mem3 [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] w1, w3;

    always @(posedge clk) begin
        if (!mem_rst_n) begin
            for (int a = 0; a < 256; a++) mem1[a] <= pat(a);
        end else if (bus1.mem_master_enable && bus1.mem_write_enable) begin
            if (bus1.mem_byte_enable) mem1[bus1.mem_addr[7:0]] <= bus1.mem_data_in[7:0];
            else for (int b = 0; b < 4; b++) mem1[w1 + 8'(b)] <= bus1.mem_data_in[8*b +: 8];
        end
    end
    assign w1 = {bus1.mem_addr[7:2], 2'b00};
    assign bus1.mem_data_out = bus1.mem_byte_enable ? {24'h0, mem1[bus1.mem_addr[7:0]]}
                             : {mem1[w1 + 8'd3], mem1[w1 + 8'd2], mem1[w1 + 8'd1], mem1[w1]};

    // Slow memory: data only valid once the address has been held for 3 cycles.
    logic [31:0] a3_q;
    int          hold3;
    always @(posedge clk) begin
        if (!mem_rst_n) for (int a = 0; a < 256; a++) mem3[a] <= pat(a);
        a3_q <= bus3.mem_addr;
        if (!bus3.mem_master_enable || bus3.mem_addr != a3_q) hold3 <= 0;
        else hold3 <= hold3 + 1;
    end
    assign w3 = {bus3.mem_addr[7:2], 2'b00};
    assign bus3.mem_data_out = (bus3.mem_addr == a3_q && hold3 >= 1)
                             ? {mem3[w3 + 8'd3], mem3[w3 + 8'd2], mem3[w3 + 8'd1], mem3[w3]}
                             : 32'hDEADBEEF;

    // ---------------- monitors ----------------
    logic [31:0] i_obs [$];
    logic [31:0] d_obs [$];
    logic [33:0] mem_log [$];
    int          i_done_cnt = 0;
    logic [31:0] obs3 [$];
    int          rv3_cyc [$];
    logic [31:0] log3 [$];

    always @(negedge clk) begin
        if (bus1.i_rvalid) i_obs.push_back(bus1.i_rdata);
        if (bus1.d_rvalid) d_obs.push_back(bus1.d_rdata);
        if (bus1.i_done) i_done_cnt <= i_done_cnt + 1;
        if (bus1.mem_master_enable)
            mem_log.push_back({bus1.mem_write_enable, bus1.mem_byte_enable, bus1.mem_addr});
        if (bus3.i_rvalid) begin
            obs3.push_back(bus3.i_rdata);
            rv3_cyc.push_back(cyc);
        end
        if (bus3.mem_master_enable) log3.push_back(bus3.mem_addr);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(logic [31:0] a, bit byt);
        logic [7:0] w;
        w = {a[7:2], 2'b00};
        if (byt) return {24'h0, ref_mem[a[7:0]]};
        return {ref_mem[w + 8'd3], ref_mem[w + 8'd2], ref_mem[w + 8'd1], ref_mem[w]};
    endfunction

    typedef struct {
        bit          port;      // 0 = I, 1 = D
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        bit          byt;
        bit          burst;
        int          exp_beats; // expected number of rvalid pulses
    } vec_t;

    // One transaction on bus1; caller is at a falling edge.
    task automatic txn(input vec_t v, input bit chk_log, input string tag,
                       output int ack_cyc, output int done_cyc);
        bit          eff_burst;
        int          nb, log0, req_cyc, nobs;
        bit          got;
        logic [31:0] a, obs;
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        eff_burst = v.burst && !(v.port && (v.we || v.byt));
        nb = eff_burst ? 4 : 1;
        for (int k = 0; k < nb; k++) begin
            a = eff_burst ? {v.addr[31:4], 2'(v.addr[3:2] + 2'(k)), 2'b00} : v.addr;
            ea.push_back(a);
            if (!v.we) ed.push_back(ref_rd(a, v.byt));
        end
        if (v.we) begin
            if (v.byt) ref_mem[v.addr[7:0]] = v.wdata[7:0];
            else for (int b = 0; b < 4; b++) ref_mem[{v.addr[7:2], 2'b00} + 8'(b)] = v.wdata[8*b +: 8];
        end
        log0 = mem_log.size();
        req_cyc = cyc;
        ack_cyc = -1;
        done_cyc = -1;
        if (v.port) begin
            bus1.d_addr = v.addr; bus1.d_wdata = v.wdata; bus1.d_we = v.we;
            bus1.d_byte = v.byt;  bus1.d_burst = v.burst; bus1.d_req = 1'b1;
        end else begin
            bus1.i_addr = v.addr; bus1.i_burst = v.burst; bus1.i_req = 1'b1;
        end
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            got = v.port ? bus1.d_ack : bus1.i_ack;
        end
        if (v.port) bus1.d_req = 1'b0; else bus1.i_req = 1'b0;
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        if (!got) return;
        ack_cyc = cyc;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            got = v.port ? bus1.d_done : bus1.i_done;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (!got) return;
        done_cyc = cyc;
        #1;
        nobs = v.port ? d_obs.size() : i_obs.size();
        chk({tag, "_beats"}, 32'(nobs), 32'(v.exp_beats));
        for (int k = 0; k < nobs; k++) begin
            obs = v.port ? d_obs.pop_front() : i_obs.pop_front();
            if (k < ed.size()) chk({tag, "_rdata"}, obs, ed[k]);
        end
        if (chk_log) begin
            chk({tag, "_ack_lat"}, 32'(ack_cyc - req_cyc), 32'd1);
            chk({tag, "_done_lat"}, 32'(done_cyc - ack_cyc), 32'(nb));
            chk({tag, "_mem_beats"}, 32'(mem_log.size() - log0), 32'(nb));
            for (int k = 0; k < nb && log0 + k < mem_log.size(); k++) begin
                chk({tag, "_mem_addr"}, mem_log[log0 + k][31:0], ea[k]);
                chk({tag, "_mem_we_be"}, 32'(mem_log[log0 + k][33:32]), 32'({v.we, v.byt}));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    vec_t tbl [11];
    vec_t vi, vd;
    int   ia, id, da, dd, c0, d0;
    bit   got;

    initial begin
        tbl[0]  = '{0, 32'h08, 32'h0,        0, 0, 0, 1};
        tbl[1]  = '{0, 32'h18, 32'h0,        0, 0, 1, 4};
        tbl[2]  = '{1, 32'h20, 32'h11223344, 1, 0, 0, 0};
        tbl[3]  = '{1, 32'h20, 32'h0,        0, 0, 0, 1};
        tbl[4]  = '{1, 32'h05, 32'h123456AB, 1, 1, 1, 0};
        tbl[5]  = '{1, 32'h05, 32'h0,        0, 1, 1, 1};
        tbl[6]  = '{1, 32'h2C, 32'h0,        0, 0, 1, 4};
        tbl[7]  = '{1, 32'h30, 32'hCAFEF00D, 1, 0, 1, 0};
        tbl[8]  = '{0, 32'h30, 32'h0,        0, 0, 1, 4};
        tbl[9]  = '{1, 32'h07, 32'h0,        0, 1, 0, 1};
        tbl[10] = '{0, 32'h04, 32'h0,        0, 0, 0, 1};

        for (int a = 0; a < 256; a++) ref_mem[a] = pat(a);
        bus1.i_req = 0; bus1.i_addr = 0; bus1.i_burst = 0;
        bus1.d_req = 0; bus1.d_addr = 0; bus1.d_wdata = 0; bus1.d_we = 0; bus1.d_byte = 0; bus1.d_burst = 0;
        bus3.i_req = 0; bus3.i_addr = 0; bus3.i_burst = 0;
        bus3.d_req = 0; bus3.d_addr = 0; bus3.d_wdata = 0; bus3.d_we = 0; bus3.d_byte = 0; bus3.d_burst = 0;
        reset = 1'b0;
        mem_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'({bus1.i_ack, bus1.i_rvalid, bus1.i_done, bus1.d_ack, bus1.d_rvalid,
                                  bus1.d_done, bus1.mem_master_enable, bus1.mem_write_enable,
                                  bus1.mem_byte_enable, bus3.mem_master_enable}), 32'd0);
        chk("reset_mem_addr", bus1.mem_addr, 32'h0);
        chk("reset_rdata", bus1.i_rdata | bus1.d_rdata, 32'h0);
        reset = 1'b1;
        mem_rst_n = 1'b1;
        @(negedge clk);

        // MEM_LATENCY=3 burst on the second instance.
        bus3.i_addr = 32'h18; bus3.i_burst = 1'b1; bus3.i_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin @(negedge clk); got = bus3.i_ack; end
        bus3.i_req = 1'b0; bus3.i_burst = 1'b0;
        chk("lat3_ack_seen", 32'(got), 32'd1);
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin @(negedge clk); got = bus3.i_done; end
        chk("lat3_done_seen", 32'(got), 32'd1);
        #1;
        chk("lat3_beats", 32'(obs3.size()), 32'd4);
        chk("lat3_mem_cycles", 32'(log3.size()), 32'd12);
        for (int k = 0; k < 4 && k < obs3.size(); k++) begin
            logic [31:0] ea3;
            ea3 = {28'h1, 2'(2'd2 + 2'(k)), 2'b00};
            chk("lat3_rdata", obs3[k], ref_rd(ea3, 1'b0));
            if (k > 0) chk("lat3_rvalid_gap", 32'(rv3_cyc[k] - rv3_cyc[k-1]), 32'd3);
            for (int j = 0; j < 3 && 3*k + j < log3.size(); j++) chk("lat3_mem_addr", log3[3*k + j], ea3);
        end

        // First tie after reset goes to I; D is served right after.
        vi = '{0, 32'h08, 32'h0, 0, 0, 0, 1};
        vd = '{1, 32'h10, 32'h0, 0, 0, 0, 1};
        c0 = cyc;
        fork
            txn(vi, 1'b0, "tie1_i", ia, id);
            txn(vd, 1'b0, "tie1_d", da, dd);
        join
        chk("tie1_i_ack", 32'(ia - c0), 32'd1);
        chk("tie1_i_done", 32'(id - c0), 32'd2);
        chk("tie1_d_ack", 32'(da - c0), 32'd3);

        // Table-driven transactions.
        for (int i = 0; i < 11; i++) begin
            txn(tbl[i], 1'b1, $sformatf("vec%0d", i), ia, id);
        end

        // After an I grant, the next tie goes to D.
        txn(vi, 1'b1, "pre_tie2", ia, id);
        c0 = cyc;
        fork
            txn(vi, 1'b0, "tie2_i", ia, id);
            txn(vd, 1'b0, "tie2_d", da, dd);
        join
        chk("tie2_d_ack", 32'(da - c0), 32'd1);
        chk("tie2_i_ack", 32'(ia - c0), 32'd3);

        // Reset during beat 2 of an I burst.
        bus1.i_addr = 32'h40; bus1.i_burst = 1'b1; bus1.i_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin @(negedge clk); got = bus1.i_ack; end
        bus1.i_req = 1'b0; bus1.i_burst = 1'b0;
        chk("rst_ack_seen", 32'(got), 32'd1);
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin @(negedge clk); got = bus1.i_rvalid; end
        chk("rst_first_rvalid", 32'(got), 32'd1);
        chk("rst_beat2_addr", bus1.mem_addr, 32'h44);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_strobes", 32'({bus1.i_ack, bus1.i_rvalid, bus1.i_done, bus1.mem_master_enable,
                                bus1.mem_write_enable, bus1.mem_byte_enable}), 32'd0);
        chk("rst_outputs_data", bus1.mem_addr | bus1.i_rdata, 32'h0);
        d0 = i_done_cnt;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_done", 32'(i_done_cnt - d0), 32'd0);
        chk("rst_beats_seen", 32'(i_obs.size()), 32'd1);
        if (i_obs.size() > 0) chk("rst_beat1_data", i_obs.pop_front(), ref_rd(32'h40, 1'b0));
        i_obs.delete();
        @(negedge clk);
        vi = '{0, 32'h40, 32'h0, 0, 0, 1, 4};
        txn(vi, 1'b1, "post_rst", ia, id);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
